// File: rtl/arcade_input_cond.sv
// Joystick conditioning for the phoenix core: 1 ms prescaler, debounce, left/right SOCD and coin pulse shaping.
// Define ARCADE_INPUT_AUTOFIRE_EN to add the autofire_on input and autofire on btn_fire.
module arcade_input_cond #(
  parameter int TICK_DIV            = 11000,
  parameter int DEBOUNCE_TICKS      = 4,
  parameter int COIN_PULSE_TICKS    = 100,
  parameter int COIN_GAP_TICKS      = 100,
  parameter int COIN_QUEUE_MAX      = 3,
  parameter int AUTOFIRE_HALF_TICKS = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pause,
  input  logic [15:0] joy,
`ifdef ARCADE_INPUT_AUTOFIRE_EN
  input  logic        autofire_on,
`endif
  output logic        btn_left,
  output logic        btn_right,
  output logic        btn_fire,
  output logic        btn_barrier,
  output logic [1:0]  btn_player_start,
  output logic        btn_coin,
  output logic [1:0]  coin_queue
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {COIN_IDLE, COIN_PULSE, COIN_GAP} coin_state_t;

  logic [CW-1:0] cnt;
  logic          tick;
  logic [6:0]    raw;
  logic [6:0]    stable;
  logic [2:0]    db_cnt [7];
  logic          coin_prev;
  logic          coin_enq;
  logic          coin_deq;
  coin_state_t   coin_state;
  logic [6:0]    tcnt;

  // Channel order: right, left, fire, barrier, start1, start2, coin
  assign raw  = {joy[8], joy[7], joy[6], joy[5], joy[4], joy[1], joy[0]};
  assign tick = (cnt == CW'(TICK_DIV - 1)) && !pause;

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (!pause)
      cnt <= (cnt == CW'(TICK_DIV - 1)) ? '0 : cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= '0;
      for (int i = 0; i < 7; i++) db_cnt[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < 7; i++) begin
        if (raw[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == 3'(DEBOUNCE_TICKS - 1)) begin
          stable[i] <= raw[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 3'd1;
        end
      end
    end
  end

  assign coin_enq = stable[6] & ~coin_prev;
  assign coin_deq = (coin_state == COIN_IDLE) && (coin_queue != 2'd0);

  // Credit queue and coin pulse FSM share one register block so a dequeue and the IDLE exit always coincide
  always_ff @(posedge clk) begin
    if (reset) begin
      coin_prev  <= 1'b0;
      coin_queue <= 2'd0;
      coin_state <= COIN_IDLE;
      tcnt       <= '0;
      btn_coin   <= 1'b0;
    end else begin
      coin_prev <= stable[6];
      if (coin_enq && !coin_deq && coin_queue != 2'(COIN_QUEUE_MAX))
        coin_queue <= coin_queue + 2'd1;
      else if (coin_deq && !coin_enq)
        coin_queue <= coin_queue - 2'd1;

      case (coin_state)
        COIN_IDLE: begin
          if (coin_queue != 2'd0) begin
            coin_state <= COIN_PULSE;
            tcnt       <= '0;
            btn_coin   <= 1'b1;
          end
        end
        COIN_PULSE: begin
          if (tick) begin
            if (tcnt == 7'(COIN_PULSE_TICKS - 1)) begin
              coin_state <= COIN_GAP;
              tcnt       <= '0;
              btn_coin   <= 1'b0;
            end else begin
              tcnt <= tcnt + 7'd1;
            end
          end
        end
        COIN_GAP: begin
          if (tick) begin
            if (tcnt == 7'(COIN_GAP_TICKS - 1)) begin
              coin_state <= COIN_IDLE;
              tcnt       <= '0;
            end else begin
              tcnt <= tcnt + 7'd1;
            end
          end
        end
        default: begin
          coin_state <= COIN_IDLE;
          tcnt       <= '0;
          btn_coin   <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
  logic [5:0] af_cnt, af_cnt_nxt;
  logic       af_phase, af_phase_nxt;
  logic       af_active, af_active_prev;
  logic       unused_joy;

  assign af_active  = autofire_on & stable[2];
  assign unused_joy = ^{joy[15:9], joy[3:2]};

  // Phase restarts high on the first active cycle so a fresh press always fires immediately
  always_comb begin
    af_cnt_nxt   = af_cnt;
    af_phase_nxt = af_phase;
    if (!af_active) begin
      af_cnt_nxt   = '0;
      af_phase_nxt = 1'b0;
    end else if (!af_active_prev) begin
      af_cnt_nxt   = '0;
      af_phase_nxt = 1'b1;
    end else if (tick) begin
      if (af_cnt == 6'(AUTOFIRE_HALF_TICKS - 1)) begin
        af_cnt_nxt   = '0;
        af_phase_nxt = ~af_phase;
      end else begin
        af_cnt_nxt = af_cnt + 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      af_cnt         <= '0;
      af_phase       <= 1'b0;
      af_active_prev <= 1'b0;
    end else begin
      af_cnt         <= af_cnt_nxt;
      af_phase       <= af_phase_nxt;
      af_active_prev <= af_active;
    end
  end
`else
  logic unused_joy;
  assign unused_joy = ^{joy[15:9], joy[3:2], AUTOFIRE_HALF_TICKS[0]};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_left         <= 1'b0;
      btn_right        <= 1'b0;
      btn_fire         <= 1'b0;
      btn_barrier      <= 1'b0;
      btn_player_start <= 2'b00;
    end else begin
      btn_left         <= stable[1] & ~stable[0];
      btn_right        <= stable[0] & ~stable[1];
      btn_barrier      <= stable[3];
      btn_player_start <= stable[5:4];
`ifdef ARCADE_INPUT_AUTOFIRE_EN
      btn_fire         <= af_active ? af_phase_nxt : stable[2];
`else
      btn_fire         <= stable[2];
`endif
    end
  end

endmodule
